// File: rtl/frame_diff_tracker_pkg.sv
// Shared types and default grid geometry for the frame-difference cell tracker.
// Object codes follow the flag index plus one, with EMPTY meaning no flag set.
package tracker_pkg;

  localparam int DEF_GRID_W     = 16;
  localparam int DEF_GRID_H     = 12;
  localparam int DEF_NUM_OBJ    = 4;
  localparam int DEF_DIFF_DEPTH = 8;

  localparam int DEF_XW = $clog2(DEF_GRID_W);
  localparam int DEF_YW = $clog2(DEF_GRID_H);
  localparam int DEF_CW = $clog2(DEF_NUM_OBJ + 1);

  typedef enum logic [DEF_CW-1:0] {
    EMPTY  = 3'd0,
    HEAD   = 3'd1,
    BODY   = 3'd2,
    APPLE  = 3'd3,
    BORDER = 3'd4
  } obj_code_t;

  typedef struct packed {
    logic [DEF_XW-1:0] x;
    logic [DEF_YW-1:0] y;
    logic [DEF_CW-1:0] code;
  } cell_entry_t;

endpackage

// File: rtl/frame_diff_tracker_if.sv
// Ready/valid change stream from the tracker (master) to the cell drawer (slave).
interface frame_diff_if #(
  parameter int XW = 4,
  parameter int YW = 4,
  parameter int CW = 3
);
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_code;

  modport master (output out_valid, out_x, out_y, out_code, input  out_ready);
  modport slave  (input  out_valid, out_x, out_y, out_code, output out_ready);
endinterface

// File: rtl/frame_diff_tracker_fifo.sv
// Generic synchronous ready/valid FIFO with extra-bit pointers and a flush that
// overrides any same-cycle read or write. A write into a full FIFO is legal only with a read.
module frame_diff_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             rd_ok, wr_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/frame_diff_tracker.sv
// Raster-scans a GRID_W x GRID_H map of object codes and queues every cell whose
// priority-encoded code differs from the stored one (or every cell when redrawing).
module frame_diff_tracker
  import tracker_pkg::*;
#(
  parameter  int GRID_W     = DEF_GRID_W,
  parameter  int GRID_H     = DEF_GRID_H,
  parameter  int NUM_OBJ    = DEF_NUM_OBJ,
  parameter  int DIFF_DEPTH = DEF_DIFF_DEPTH,
  localparam int XW         = $clog2(GRID_W),
  localparam int YW         = $clog2(GRID_H),
  localparam int CW         = $clog2(NUM_OBJ + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               enable,
  input  logic               sync,
  input  logic               force_redraw,
  input  logic [NUM_OBJ-1:0] obj_flags,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      obj_code,
  output logic               diff,
  output logic               frame_done,
  output logic               overflow,
  frame_diff_if.master       out_if
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = $clog2(NCELL);
  localparam int EW    = XW + YW + CW;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] map_q [NCELL];
  logic          overflow_q;

  logic [IW-1:0] cell_idx;
  logic          at_row_end, at_last;
  logic          fifo_full, fifo_empty, pop, push;
  logic [EW-1:0] head;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    obj_code = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (obj_flags[i]) obj_code = CW'(i + 1);
    end
  end

  assign cell_idx   = IW'(y_q) * IW'(GRID_W) + IW'(x_q);
  assign at_row_end = (x_q == XW'(GRID_W - 1));
  assign at_last    = at_row_end && (y_q == YW'(GRID_H - 1));

  assign x          = x_q;
  assign y          = y_q;
  assign diff       = enable && ((obj_code != map_q[cell_idx]) || force_redraw);
  assign frame_done = enable && at_last;
  assign overflow   = overflow_q;

  // A full FIFO still accepts a change when the drawer takes the head in the same cycle.
  assign pop  = !fifo_empty && out_if.out_ready;
  assign push = diff && !sync && (!fifo_full || pop);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (sync) begin
      x_q <= '0;
      y_q <= '0;
    end else if (enable) begin
      if (at_row_end) begin
        x_q <= '0;
        y_q <= at_last ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // The map is architectural state that must read as empty after reset or sync.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCELL; i++) map_q[i] <= '0;
    end else if (sync) begin
      for (int i = 0; i < NCELL; i++) map_q[i] <= '0;
    end else if (push) begin
      map_q[cell_idx] <= obj_code;
    end
  end

  // A dropped change leaves the map untouched so the cell re-reports next frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overflow_q <= 1'b0;
    end else if (sync) begin
      overflow_q <= 1'b0;
    end else if (diff && !push) begin
      overflow_q <= 1'b1;
    end
  end

  frame_diff_fifo #(
    .WIDTH (EW),
    .DEPTH (DIFF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .flush   (sync),
    .wr_en   (push),
    .wr_data ({x_q, y_q, obj_code}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head fields are forced to zero while empty so stale storage is never presented.
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_x     = fifo_empty ? '0 : head[EW-1 -: XW];
  assign out_if.out_y     = fifo_empty ? '0 : head[CW +: YW];
  assign out_if.out_code  = fifo_empty ? '0 : head[CW-1:0];

endmodule

// File: tb/tb_frame_diff_tracker.sv
// Directed bench for frame_diff_tracker: table-driven encoder/diff vectors plus
// hand-written sequences for frame wrap, FIFO full/overflow, sync, redraw and reset.
module tb_frame_diff_tracker;
  import tracker_pkg::*;

  localparam int NCELL = DEF_GRID_W * DEF_GRID_H;

  logic       clk = 1'b0;
  logic       nrst;
  logic       enable, sync, force_redraw;
  logic [3:0] obj_flags;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       diff, frame_done, overflow;

  frame_diff_if #(.XW(DEF_XW), .YW(DEF_YW), .CW(DEF_CW)) ifc ();

  frame_diff_tracker dut (
    .clk          (clk),
    .nrst         (nrst),
    .enable       (enable),
    .sync         (sync),
    .force_redraw (force_redraw),
    .obj_flags    (obj_flags),
    .x            (x),
    .y            (y),
    .obj_code     (obj_code),
    .diff         (diff),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .out_if       (ifc.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic       frc;
    obj_code_t  exp_code;
    logic       exp_diff;
  } vec_t;

  vec_t vt [11];
  int   n_vec = 0;
  int   n_err = 0;
  int   pos   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (sync) pos = 0;
    else if (enable) pos = (pos + 1) % NCELL;
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] fl, input logic frc, input logic rdy);
    enable = en; obj_flags = fl; force_redraw = frc; ifc.out_ready = rdy; sync = 1'b0;
  endtask

  task automatic goto_cell(input int target);
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    while (pos != target) tick();
  endtask

  task automatic check_head(input string name, input int ex, input int ey, input int ec);
    check({name, " valid"}, int'(ifc.out_valid), 1);
    check({name, " x"}, int'(ifc.out_x), ex);
    check({name, " y"}, int'(ifc.out_y), ey);
    check({name, " code"}, int'(ifc.out_code), ec);
  endtask

  initial begin
    int bad, fd_cnt, fd_pos, entries;

    vt[0]  = '{4'b0000, 1'b0, EMPTY,  1'b0};
    vt[1]  = '{4'b0001, 1'b0, HEAD,   1'b1};
    vt[2]  = '{4'b0010, 1'b0, BODY,   1'b1};
    vt[3]  = '{4'b0100, 1'b0, APPLE,  1'b1};
    vt[4]  = '{4'b1000, 1'b0, BORDER, 1'b1};
    vt[5]  = '{4'b1001, 1'b0, BORDER, 1'b1};
    vt[6]  = '{4'b0110, 1'b0, APPLE,  1'b1};
    vt[7]  = '{4'b0011, 1'b0, BODY,   1'b1};
    vt[8]  = '{4'b0000, 1'b1, EMPTY,  1'b1};
    vt[9]  = '{4'b1111, 1'b0, BORDER, 1'b1};
    vt[10] = '{4'b0101, 1'b0, APPLE,  1'b1};

    nrst = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    #2;
    check("rst x", int'(x), 0);
    check("rst y", int'(y), 0);
    check("rst out_valid", int'(ifc.out_valid), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst out_x", int'(ifc.out_x), 0);
    check("rst out_y", int'(ifc.out_y), 0);
    check("rst out_code", int'(ifc.out_code), 0);
    check("rst diff", int'(diff), 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Empty frame: no diffs, a single frame_done at the last cell.
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    bad = 0; fd_cnt = 0; fd_pos = -1;
    for (int k = 0; k < NCELL; k++) begin
      #1;
      if (diff) bad++;
      if (frame_done) begin fd_cnt++; fd_pos = k; end
      tick();
    end
    check("empty frame diffs", bad, 0);
    check("empty frame frame_done count", fd_cnt, 1);
    check("empty frame frame_done pos", fd_pos, NCELL - 1);
    check("empty frame wrap x", int'(x), 0);
    check("empty frame wrap y", int'(y), 0);
    check("empty frame out_valid", int'(ifc.out_valid), 0);

    // Table: encoder and diff on an empty row, with one-cycle FIFO latency.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].flags, vt[i].frc, 1'b1);
      #1;
      check($sformatf("vec%0d x", i), int'(x), i);
      check($sformatf("vec%0d code", i), int'(obj_code), int'(vt[i].exp_code));
      check($sformatf("vec%0d diff", i), int'(diff), int'(vt[i].exp_diff));
      if (i > 0) begin
        check($sformatf("vec%0d prev valid", i), int'(ifc.out_valid), int'(vt[i-1].exp_diff));
        if (vt[i-1].exp_diff) begin
          check($sformatf("vec%0d prev out_x", i), int'(ifc.out_x), i - 1);
          check($sformatf("vec%0d prev out_code", i), int'(ifc.out_code), int'(vt[i-1].exp_code));
        end
      end
      tick();
    end

    // Border beats head at (3,2); unchanged next frame.
    goto_cell(35);
    drive(1'b1, 4'b1001, 1'b0, 1'b1);
    #1;
    check("c32 x", int'(x), 3);
    check("c32 y", int'(y), 2);
    check("c32 code", int'(obj_code), 4);
    check("c32 diff", int'(diff), 1);
    tick();
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    check_head("c32 head", 3, 2, 4);
    goto_cell(35);
    drive(1'b1, 4'b1001, 1'b0, 1'b1);
    #1;
    check("c32 again diff", int'(diff), 0);
    tick();

    // Fill the FIFO with 8 changes while the drawer stalls.
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    repeat (8) tick();
    check_head("full head", 4, 2, 1);
    check("full overflow", int'(overflow), 0);
    // Full with pop and push in the same cycle.
    drive(1'b1, 4'b0010, 1'b0, 1'b1);
    #1;
    check("poppush diff", int'(diff), 1);
    tick();
    check("poppush overflow", int'(overflow), 0);
    check_head("poppush head", 5, 2, 1);
    // Still full: the next change is dropped.
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    #1;
    check("drop diff", int'(diff), 1);
    tick();
    check("drop overflow", int'(overflow), 1);
    check_head("drop head stable", 5, 2, 1);
    // Drain: exactly 8 entries in order.
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (!ifc.out_valid || int'(ifc.out_x) != ((k < 7) ? 5 + k : 12) ||
          ifc.out_y != 4'd2 || int'(ifc.out_code) != ((k < 7) ? 1 : 2)) bad++;
      tick();
    end
    check("drain order", bad, 0);
    check("drain empty", int'(ifc.out_valid), 0);
    check("drain overflow sticky", int'(overflow), 1);
    // Dropped cell re-reports next frame.
    goto_cell(45);
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    #1;
    check("rereport diff", int'(diff), 1);
    tick();

    // Sync mid-frame at (7,5) with a queued entry.
    goto_cell(86);
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    tick();
    check("presync x", int'(x), 7);
    check("presync y", int'(y), 5);
    check("presync valid", int'(ifc.out_valid), 1);
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync x", int'(x), 0);
    check("sync y", int'(y), 0);
    check("sync valid", int'(ifc.out_valid), 0);
    check("sync overflow", int'(overflow), 0);
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    bad = 0;
    while (pos <= 45) begin
      #1;
      if (diff) bad++;
      tick();
    end
    check("sync cleared map diffs", bad, 0);
    goto_cell(86);
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    #1;
    check("sync head cell rereport", int'(diff), 1);
    tick();
    goto_cell(0);

    // Forced redraw of a whole frame.
    drive(1'b1, 4'b0000, 1'b1, 1'b1);
    bad = 0; entries = 0; fd_cnt = 0;
    for (int k = 0; k < NCELL; k++) begin
      #1;
      if (!diff) bad++;
      if (frame_done && k != NCELL - 1) bad++;
      if (frame_done) fd_cnt++;
      if (k > 0) begin
        if (!ifc.out_valid || int'(ifc.out_x) != (k - 1) % 16 ||
            int'(ifc.out_y) != (k - 1) / 16 || ifc.out_code != 3'd0) bad++;
      end
      if (ifc.out_valid) entries++;
      tick();
    end
    if (ifc.out_valid) entries++;
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    check("redraw errors", bad, 0);
    check("redraw entries", entries, NCELL);
    check("redraw frame_done", fd_cnt, 1);

    // Asynchronous reset while an entry is queued.
    drive(1'b1, 4'b0100, 1'b0, 1'b0);
    tick();
    check("prereset valid", int'(ifc.out_valid), 1);
    #2 nrst = 1'b0;
    #1;
    check("midreset valid", int'(ifc.out_valid), 0);
    check("midreset out_x", int'(ifc.out_x), 0);
    check("midreset out_code", int'(ifc.out_code), 0);
    check("midreset x", int'(x), 0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 nrst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
